// File: rtl/i_cache.sv
// Direct-mapped instruction cache with a single outstanding line refill.
// A request accepted in cycle N is looked up in cycle N+1. A hit responds in
// that cycle. A miss fetches the whole line from backing memory, one word per
// beat in ascending order, and then returns the missed word.
module i_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   o_req_ready,
  input  logic                   i_kill,
  input  logic                   i_flush,
  output logic                   o_rsp_valid,
  output logic [INSTR_WIDTH-1:0] o_rsp_instr,
  output logic [ADDR_WIDTH-1:0]  o_rsp_addr,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS_REQ,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Line storage. Only the valid bits need a defined value after reset.
  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [INSTR_WIDTH-1:0] r_data [NUM_LINES*WORDS_PER_LINE];

  // The pending lookup also serves as the miss address for the refill.
  logic                  r_pend_valid;
  logic [ADDR_WIDTH-1:0] r_pend_addr;

  logic [OFF_W-1:0] r_beat;
  logic             r_killed;   // refill result must not be returned
  logic             r_flushed;  // refilled line must stay invalid

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_lookup;
  logic             w_last_beat;
  logic             w_refill_beat;
  logic             w_accept;
  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_mem_req_valid;

  assign w_off = r_pend_addr[2 +: OFF_W];
  assign w_idx = r_pend_addr[2 + OFF_W +: IDX_W];
  assign w_tag = r_pend_addr[ADDR_WIDTH-1 -: TAG_W];

  // A flush in the lookup cycle turns the lookup into a miss.
  assign w_hit         = r_pend_valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !i_flush;
  assign w_lookup      = (r_state == S_IDLE) && r_pend_valid;
  assign w_refill_beat = (r_state == S_REFILL) && i_mem_rsp_valid;
  assign w_last_beat   = w_refill_beat && (r_beat == LAST_BEAT);
  assign w_accept      = i_req_valid && w_req_ready;

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_req_ready     = 1'b0;
    w_rsp_valid     = 1'b0;
    w_mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !i_kill && !i_flush && !(r_pend_valid && !w_hit);
        if (w_lookup && !i_kill) begin
          if (w_hit) w_rsp_valid = 1'b1;
          else       w_state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        w_mem_req_valid = 1'b1;
        if (i_mem_req_ready) w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (w_last_beat) w_state_nxt = (r_killed || i_kill) ? S_IDLE : S_RESPOND;
      end
      S_RESPOND: begin
        w_rsp_valid = !i_kill;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Pending lookup: captured on accept, dropped once the FSM settles in IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= i_req_addr;
    end else if (w_state_nxt == S_IDLE) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Beat counter and sticky kill/flush flags for the refill in progress.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_beat    <= '0;
      r_killed  <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      if (w_refill_beat) r_beat <= r_beat + OFF_W'(1);
      if (r_state == S_IDLE) begin
        r_killed  <= 1'b0;
        r_flushed <= 1'b0;
      end else begin
        if (i_kill)  r_killed  <= 1'b1;
        if (i_flush) r_flushed <= 1'b1;
      end
    end
  end

  // Valid bits: a flush wins over validating the line on its last beat.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                    r_valid        <= '0;
    else if (i_flush)                  r_valid        <= '0;
    else if (w_last_beat && !r_flushed) r_valid[w_idx] <= 1'b1;
  end

  // Data and tag arrays are written by the refill only.
  always_ff @(posedge i_clk) begin
    // NOTE: no reset on the arrays; a line is unreadable until its valid bit
    // is set, which happens only after every word has been written.
    if (w_refill_beat) r_data[{w_idx, r_beat}] <= i_mem_rsp_data;
    if (w_last_beat)   r_tag[w_idx]            <= w_tag;
  end

  // All outputs read as zero while reset is held.
  assign o_req_ready     = i_reset_n && w_req_ready;
  assign o_rsp_valid     = i_reset_n && w_rsp_valid;
  assign o_mem_req_valid = i_reset_n && w_mem_req_valid;
  assign o_rsp_instr     = i_reset_n ? r_data[{w_idx, w_off}] : '0;
  assign o_rsp_addr      = i_reset_n ? r_pend_addr : '0;
  assign o_mem_addr      = i_reset_n ? {r_pend_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}} : '0;

endmodule

// File: tb/tb_i_cache.sv
// Scoreboard bench for i_cache: fetches push expected responses, a monitor
// pops them on o_rsp_valid, and a memory model serves line refills.
module tb_i_cache;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        o_req_ready;
  logic        i_kill;
  logic        i_flush;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_instr;
  logic [31:0] o_rsp_addr;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_req_ready;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;

  i_cache dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_req_valid     (i_req_valid),
    .i_req_addr      (i_req_addr),
    .o_req_ready     (o_req_ready),
    .i_kill          (i_kill),
    .i_flush         (i_flush),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_instr     (o_rsp_instr),
    .o_rsp_addr      (o_rsp_addr),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_addr      (o_mem_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          acc;
    int          lat;   // 0 = latency not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 0;
  bit          mem_gap  = 1'b0;
  int          mem_beat = -1;
  int          wait_cnt = 0;
  logic [31:0] line     = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] ln, input int w);
    if (ln == 32'h100) return 32'hA0 + 32'(w);
    return {ln[23:0], 8'h00} | (32'hB0 + 32'(w));
  endfunction

  // Response monitor: every response must match the oldest expectation.
  always @(negedge i_clk) begin
    #2;
    if (o_rsp_valid) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_addr", 64'(o_rsp_addr), 64'(e.addr));
        check("rsp_instr", 64'(o_rsp_instr), 64'(e.instr));
        if (e.lat != 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Backing memory: optional accept latency and inter-beat gaps.
  initial begin
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    forever begin
      @(negedge i_clk);
      #1;
      if (!(i_reset_n && o_mem_req_valid)) begin
        wait_cnt = 0;
        continue;
      end
      if (wait_cnt == 0) line = o_mem_addr;
      else check("mem_addr_stable", 64'(o_mem_addr), 64'(line));
      if (wait_cnt < mem_lat) begin
        wait_cnt++;
        continue;
      end
      wait_cnt = 0;
      i_mem_req_ready = 1'b1;
      @(negedge i_clk);
      i_mem_req_ready = 1'b0;
      check("mem_req_expected", 64'(mem_q.size() != 0), 64'd1);
      if (mem_q.size() != 0) check("mem_addr", 64'(line), 64'(mem_q.pop_front()));
      for (int w = 0; w < 4; w++) begin
        if (!i_reset_n) break;
        if (mem_gap && w != 0) begin
          i_mem_rsp_valid = 1'b0;
          mem_beat        = -1;
          @(negedge i_clk);
          if (!i_reset_n) break;
        end
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = mem_word(line, w);
        mem_beat        = w;
        @(negedge i_clk);
      end
      i_mem_rsp_valid = 1'b0;
      mem_beat        = -1;
    end
  end

  // Issue one fetch; returns at the negedge of the lookup cycle.
  task automatic send(input logic [31:0] addr, input logic [31:0] instr,
                      input bit exp_rsp, input int lat);
    bit acc = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (o_req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    check("req_accepted", 64'(acc), 64'd1);
    if (acc && exp_rsp) exp_q.push_back('{addr, instr, cyc, lat});
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge i_clk);
      c++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge i_clk);
    check("mem_reqs_done", 64'(mem_q.size()), 64'd0);
  endtask

  // Returns at +1 after the negedge on which beat b is driven.
  task automatic wait_beat(input int b);
    bit seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      #1;
      if (i_mem_rsp_valid && mem_beat == b) begin
        seen = 1'b1;
        break;
      end
    end
    check("beat_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    check({tag, "_mem_valid"}, 64'(o_mem_req_valid), 64'd0);
    check({tag, "_rsp_instr"}, 64'(o_rsp_instr), 64'd0);
    check({tag, "_rsp_addr"}, 64'(o_rsp_addr), 64'd0);
    check({tag, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    i_reset_n   = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h104;
    i_kill      = 1'b0;
    i_flush     = 1'b0;

    // Reset: outputs held at zero even with a request presented.
    repeat (3) @(negedge i_clk);
    #2;
    check_all_zero("reset");
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_reset_n   = 1'b1;
    @(negedge i_clk);
    #2;
    check("idle_ready", 64'(o_req_ready), 64'd1);
    check("idle_rsp_valid", 64'(o_rsp_valid), 64'd0);
    @(negedge i_clk);

    // Cold miss on 0x104.
    mem_q.push_back(32'h100);
    send(32'h104, 32'hA1, 1'b1, 0);
    #2;
    check("miss_ready_low", 64'(o_req_ready), 64'd0);
    @(negedge i_clk);
    drain();
    #2;
    check("ready_after_respond", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);

    // Four back-to-back hits on the same line.
    c0 = cyc;
    for (int w = 0; w < 4; w++) send(32'h100 + 32'(4 * w), 32'hA0 + 32'(w), 1'b1, 1);
    check("b2b_cycles", 64'(cyc - c0), 64'd4);
    drain();

    // Conflict miss with slow accept and beat gaps, then replaced line.
    mem_lat = 2;
    mem_gap = 1'b1;
    mem_q.push_back(32'h200);
    send(32'h204, mem_word(32'h200, 1), 1'b1, 0);
    drain();
    mem_lat = 0;
    mem_gap = 1'b0;
    send(32'h200, mem_word(32'h200, 0), 1'b1, 1);
    drain();
    mem_q.push_back(32'h100);
    send(32'h10C, 32'hA3, 1'b1, 0);
    drain();

    // Kill in the second refill beat: no response, but the line is valid.
    mem_q.push_back(32'h300);
    send(32'h300, 32'h0, 1'b0, 0);
    wait_beat(1);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    repeat (10) @(negedge i_clk);
    send(32'h300, mem_word(32'h300, 0), 1'b1, 1);
    drain();

    // Flush during refill: response delivered, line left invalid.
    mem_q.push_back(32'h400);
    send(32'h408, mem_word(32'h400, 2), 1'b1, 0);
    wait_beat(1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    drain();
    mem_q.push_back(32'h400);
    send(32'h400, mem_word(32'h400, 0), 1'b1, 0);
    drain();

    // Flush in the lookup cycle turns a hit into a miss.
    mem_q.push_back(32'h400);
    send(32'h404, mem_word(32'h400, 1), 1'b1, 0);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    drain();

    // Kill in the lookup cycle suppresses a hit; the next fetch still hits.
    send(32'h408, 32'h0, 1'b0, 0);
    i_kill = 1'b1;
    #2;
    check("kill_ready_low", 64'(o_req_ready), 64'd0);
    @(negedge i_clk);
    i_kill = 1'b0;
    repeat (2) @(negedge i_clk);
    send(32'h40C, mem_word(32'h400, 3), 1'b1, 1);
    drain();

    // Reset in refill beat 2 abandons the refill.
    mem_q.push_back(32'h500);
    send(32'h500, 32'h0, 1'b0, 0);
    wait_beat(2);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    #2;
    check_all_zero("mid_refill_reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);
    mem_q.push_back(32'h500);
    send(32'h500, mem_word(32'h500, 0), 1'b1, 0);
    drain();

    // A second index leaves index 0 untouched.
    mem_q.push_back(32'h510);
    send(32'h514, mem_word(32'h510, 1), 1'b1, 0);
    drain();
    send(32'h500, mem_word(32'h500, 0), 1'b1, 1);
    send(32'h51C, mem_word(32'h510, 3), 1'b1, 1);
    drain();

    check("final_rsp_q", 64'(exp_q.size()), 64'd0);
    check("final_mem_q", 64'(mem_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
